f_reg_file_sb: RTL and testbench
================================

# f_reg_file_sb

Parametrised floating-point register file with an integrated per-register pending scoreboard, write-port priority and optional write-to-read bypass. It is the next generation of the MicroGT-01 FP register file. It sits between FP issue and the FP writeback ports:
- Issue reserves a destination register.
- Writeback clears the reservation and stores the result.
- Read ports report both data and operand readiness, so issue can stall without a separate hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register.
- DEPTH, 32, number of registers; AW = $clog2(DEPTH).
- WRITE_PORTS, 2, number of write (writeback) ports.
- READ_PORTS, 6, number of read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- clk_en_i  in  1  clock enable; when 0 no state changes (registers, pending bits, counter all hold).
- flush_i  in  1  synchronous flush of all pending bits; register contents are kept.
- we_i  in  WRITE_PORTS  write enable per port.
- wr_addr_i  in  WRITE_PORTS x AW  write address per port.
- wr_data_i  in  WRITE_PORTS x DATA_WIDTH  write data per port.
- rsv_valid_i  in  1  reserve destination register rsv_addr_i.
- rsv_addr_i  in  AW  register to mark pending.
- rsv_ready_o  out  1  reservation can be accepted this cycle.
- rd_addr_i  in  READ_PORTS x AW  read address per port.
- rd_data_o  out  READ_PORTS x DATA_WIDTH  read data per port.
- rd_valid_o  out  READ_PORTS  operand ready (not pending, or bypassed).
- pending_cnt_o  out  $clog2(DEPTH+1)  number of registers currently pending.

## Operation
- Storage:
  - DEPTH x DATA_WIDTH registers plus DEPTH pending bits, both flip-flop based.
  - Reset (rst_n_i low, asynchronous) clears all registers, all pending bits and pending_cnt_o to 0.
- Write:
  - Register j is written when any port i has we_i[i]=1 and wr_addr_i[i]=j.
  - Multiple ports hitting the same register: the highest-index port wins.
  - Out-of-range addresses (>= DEPTH) are ignored.
- Pending clear: a write to a pending register clears its pending bit.
- Reservation:
  - A reservation is accepted when rsv_valid_i && rsv_ready_o; it sets pending[rsv_addr_i].
  - rsv_ready_o = !pending[rsv_addr_i] || (a write to rsv_addr_i this cycle). This blocks WAW on an outstanding producer.
  - rsv_ready_o is combinational and independent of rsv_valid_i.
- Simultaneous set and clear of the same register in one cycle: set wins, because the new producer supersedes the old one.
- Flush:
  - flush_i=1 clears all pending bits and ignores any reservation that cycle.
  - Writes in the same cycle still update data.
  - pending_cnt_o becomes 0.
- Read, combinational:
  - With BYPASS=1 and a same-cycle write to rd_addr_i[k] (highest-index matching port): rd_data_o[k] = that wr_data_i and rd_valid_o[k]=1.
  - Otherwise rd_data_o[k] = stored value and rd_valid_o[k] = !pending[rd_addr_i[k]].
  - With BYPASS=0, reads always return the stored value and pending state.
  - Out-of-range read address: data 0, valid 1.
- Counter: pending_cnt_o tracks the popcount of the pending bits. It is updated incrementally as (accepted set) minus (number of distinct pending registers cleared and not re-set). It never wraps: the range 0..DEPTH is guaranteed by construction.

## Timing
- Write latency: 1 cycle to storage. Data is visible on the read port the cycle after the write edge, or the same cycle via bypass.
- Reservation: rd_valid_o for that register drops the cycle after acceptance.
- Clear: rd_valid_o rises the same cycle as the write with BYPASS=1, or the next cycle with BYPASS=0.
- clk_en_i=0: the edge is ignored entirely. Combinational outputs still reflect current inputs and stored state.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. The first edge after deassertion behaves normally.

## Test plan
- Reset then read all six ports at addresses 0..5 -> rd_data_o all 0, rd_valid_o all 1, pending_cnt_o=0, rsv_ready_o=1.
- Port0 writes f3=0x3F800000 and port1 writes f3=0x40000000 in the same cycle -> next cycle rd f3=0x40000000. With BYPASS=1 the same-cycle read also shows 0x40000000.
- Reserve f7 -> next cycle rd_valid(f7)=0, pending_cnt_o=1, rsv_ready_o=0 for f7.
  - Then write f7=0x41200000 with a same-cycle reservation of f7 -> rsv_ready_o=1, f7 stays pending, data=0x41200000, pending_cnt_o=1.
- Reserve f1, f2, f4, then flush_i together with a write f2=0xC0000000 -> pending_cnt_o=0, all rd_valid_o=1, f2=0xC0000000.
- clk_en_i=0 with we_i=2'b11 and rsv_valid_i=1 -> no register, pending or counter change on the edge.
- Assert rst_n_i low between clock edges while f5 is pending and holds 0x12345678 -> outputs clear immediately: rd f5=0, valid=1, pending_cnt_o=0.

Source files
------------

// File: rtl/f_reg_file_sb.sv
// FP register file with a per-register pending scoreboard, prioritised write ports
// and optional write-to-read bypass.
module f_reg_file_sb #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WRITE_PORTS = 2,
    parameter int READ_PORTS  = 6,
    parameter int BYPASS      = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic                                    clk_en_i,
    input  logic                                    flush_i,
    input  logic [WRITE_PORTS-1:0]                  we_i,
    input  logic [WRITE_PORTS-1:0][AW-1:0]          wr_addr_i,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wr_data_i,
    input  logic                                    rsv_valid_i,
    input  logic [AW-1:0]                           rsv_addr_i,
    output logic                                    rsv_ready_o,
    input  logic [READ_PORTS-1:0][AW-1:0]           rd_addr_i,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   rd_data_o,
    output logic [READ_PORTS-1:0]                   rd_valid_o,
    output logic [CW-1:0]                           pending_cnt_o
);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pending_q;
    logic [CW-1:0]         cnt_q;

    logic [DEPTH-1:0]      wr_hit;
    logic [DATA_WIDTH-1:0] wr_val [DEPTH];
    logic                  rsv_in;
    logic                  rsv_ready;
    logic [DEPTH-1:0]      set_vec;
    logic [DEPTH-1:0]      pend_d;
    logic                  new_set;
    logic [CW-1:0]         n_clr;
    logic [CW-1:0]         cnt_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Per-register write decode; ascending port order lets the highest index win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_hit = '0;
        for (int j = 0; j < DEPTH; j++) wr_val[j] = '0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            if (we_i[i] && in_range(wr_addr_i[i])) begin
                wr_hit[wr_addr_i[i]] = 1'b1;
                wr_val[wr_addr_i[i]] = wr_data_i[i];
            end
        end
    end

    // A reservation may replace an outstanding producer only if that producer retires this cycle.
    always_comb begin
        rsv_in    = in_range(rsv_addr_i);
        rsv_ready = 1'b1;
        set_vec   = '0;
        if (rsv_in) rsv_ready = !pending_q[rsv_addr_i] || wr_hit[rsv_addr_i];
        if (rsv_valid_i && rsv_ready && rsv_in && !flush_i) set_vec[rsv_addr_i] = 1'b1;
    end

    assign rsv_ready_o = rsv_ready;

    // Set beats clear; the counter only moves for registers whose pending bit actually toggles.
    always_comb begin
        pend_d  = flush_i ? '0 : ((pending_q & ~wr_hit) | set_vec);
        new_set = |(set_vec & ~pending_q);
        n_clr   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            n_clr = n_clr + CW'(pending_q[j] & wr_hit[j] & ~set_vec[j]);
        end
        cnt_d = flush_i ? '0 : (cnt_q + CW'(new_set) - n_clr);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: storage is reset too, because reads must return 0 immediately after reset.
            for (int j = 0; j < DEPTH; j++) regs_q[j] <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else if (clk_en_i) begin
            // NOTE: non-blocking assignments so all state samples pre-edge values.
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_hit[j]) regs_q[j] <= wr_val[j];
            end
            pending_q <= pend_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;

    always_comb begin
        for (int k = 0; k < READ_PORTS; k++) begin
            rd_data_o[k]  = '0;
            rd_valid_o[k] = 1'b1;
            if (in_range(rd_addr_i[k])) begin
                if (BYPASS != 0 && wr_hit[rd_addr_i[k]]) begin
                    rd_data_o[k] = wr_val[rd_addr_i[k]];
                end else begin
                    rd_data_o[k]  = regs_q[rd_addr_i[k]];
                    rd_valid_o[k] = !pending_q[rd_addr_i[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_f_reg_file_sb.sv
// Self-checking bench for f_reg_file_sb: a reference model of registers and pending flags
// checked every cycle, plus literal expectations from the directed scenarios.
module tb_f_reg_file_sb;

    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int WP     = 2;
    localparam int RP     = 6;
    localparam int BYPASS = 1;
    localparam int AW     = 5;
    localparam int CW     = 6;

    logic                        clk_i = 1'b0;
    logic                        rst_n_i;
    logic                        clk_en_i;
    logic                        flush_i;
    logic [WP-1:0]               we_i;
    logic [WP-1:0][AW-1:0]       wr_addr_i;
    logic [WP-1:0][DW-1:0]       wr_data_i;
    logic                        rsv_valid_i;
    logic [AW-1:0]               rsv_addr_i;
    logic                        rsv_ready_o;
    logic [RP-1:0][AW-1:0]       rd_addr_i;
    logic [RP-1:0][DW-1:0]       rd_data_o;
    logic [RP-1:0]               rd_valid_o;
    logic [CW-1:0]               pending_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_pend [DEPTH];

    f_reg_file_sb #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .WRITE_PORTS(WP),
        .READ_PORTS (RP),
        .BYPASS     (BYPASS)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clk_en_i     (clk_en_i),
        .flush_i      (flush_i),
        .we_i         (we_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .rsv_valid_i  (rsv_valid_i),
        .rsv_addr_i   (rsv_addr_i),
        .rsv_ready_o  (rsv_ready_o),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .pending_cnt_o(pending_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model helpers: is register a written this cycle, and by which data (last port wins).
    function automatic bit m_written(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bit hit = 1'b0;
        d = '0;
        for (int i = 0; i < WP; i++) begin
            if (we_i[i] && wr_addr_i[i] == a) begin
                hit = 1'b1;
                d   = wr_data_i[i];
            end
        end
        return hit;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int j = 0; j < DEPTH; j++) c += int'(m_pend[j]);
        return c;
    endfunction

    // Reference model: registers and pending flags advance on each enabled edge.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                m_reg[j]  = '0;
                m_pend[j] = 1'b0;
            end
        end else if (clk_en_i) begin
            logic [DW-1:0] d;
            bit            ready;
            bit            old_pend [DEPTH];
            for (int j = 0; j < DEPTH; j++) old_pend[j] = m_pend[j];
            ready = !old_pend[rsv_addr_i] || m_written(rsv_addr_i, d);
            for (int j = 0; j < DEPTH; j++) begin
                if (m_written(AW'(j), d)) begin
                    m_reg[j]  = d;
                    m_pend[j] = 1'b0;
                end
            end
            if (flush_i) begin
                for (int j = 0; j < DEPTH; j++) m_pend[j] = 1'b0;
            end else if (rsv_valid_i && ready) begin
                m_pend[rsv_addr_i] = 1'b1;
            end
        end
    end

    // Compare process: every mid-cycle, all combinational outputs against the model.
    always @(negedge clk_i) begin
        if (cmp_en && rst_n_i) begin
            logic [DW-1:0] d;
            logic [DW-1:0] exp_d;
            bit            exp_v;
            bit            exp_r;
            for (int k = 0; k < RP; k++) begin
                if (BYPASS != 0 && m_written(rd_addr_i[k], d)) begin
                    exp_d = d;
                    exp_v = 1'b1;
                end else begin
                    exp_d = m_reg[rd_addr_i[k]];
                    exp_v = !m_pend[rd_addr_i[k]];
                end
                check($sformatf("model rd_data[%0d]", k), rd_data_o[k], exp_d);
                check($sformatf("model rd_valid[%0d]", k), rd_valid_o[k], exp_v);
            end
            exp_r = !m_pend[rsv_addr_i] || m_written(rsv_addr_i, d);
            check("model rsv_ready", rsv_ready_o, exp_r);
            check("model pending_cnt", pending_cnt_o, m_count());
        end
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle();
        clk_en_i    = 1'b1;
        flush_i     = 1'b0;
        we_i        = '0;
        rsv_valid_i = 1'b0;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        idle();
        rsv_valid_i = 1'b1;
        rsv_addr_i  = a;
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i   = 1'b0;
        idle();
        wr_addr_i = '0;
        wr_data_i = '0;
        rsv_addr_i = '0;
        for (int k = 0; k < RP; k++) rd_addr_i[k] = AW'(k);
        repeat (2) cycle();
        rst_n_i = 1'b1;
        cmp_en  = 1'b1;

        // Reset state on ports 0..5
        settle();
        for (int k = 0; k < RP; k++) begin
            check($sformatf("reset rd_data[%0d]", k), rd_data_o[k], 32'h0);
            check($sformatf("reset rd_valid[%0d]", k), rd_valid_o[k], 1'b1);
        end
        check("reset pending_cnt", pending_cnt_o, 0);
        check("reset rsv_ready", rsv_ready_o, 1'b1);
        cycle();

        // Two ports hit f3: port1 wins, visible via bypass and after the edge
        we_i = 2'b11;
        wr_addr_i[0] = 5'd3; wr_data_i[0] = 32'h3F80_0000;
        wr_addr_i[1] = 5'd3; wr_data_i[1] = 32'h4000_0000;
        rd_addr_i[0] = 5'd3;
        settle();
        check("f3 bypass data", rd_data_o[0], 32'h4000_0000);
        check("f3 bypass valid", rd_valid_o[0], 1'b1);
        cycle();
        idle();
        settle();
        check("f3 stored data", rd_data_o[0], 32'h4000_0000);
        cycle();

        // Reserve f7
        rd_addr_i[1] = 5'd7;
        reserve(5'd7);
        idle();
        rsv_addr_i = 5'd7;
        settle();
        check("f7 rsv valid", rd_valid_o[1], 1'b0);
        check("f7 rsv cnt", pending_cnt_o, 1);
        check("f7 rsv ready", rsv_ready_o, 1'b0);
        cycle();

        // Write f7 with same-cycle reservation of f7: set beats clear
        we_i = 2'b01;
        wr_addr_i[0] = 5'd7; wr_data_i[0] = 32'h4120_0000;
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd7;
        settle();
        check("f7 wr+rsv ready", rsv_ready_o, 1'b1);
        check("f7 wr+rsv bypass", rd_data_o[1], 32'h4120_0000);
        cycle();
        idle();
        settle();
        check("f7 still pending", rd_valid_o[1], 1'b0);
        check("f7 data", rd_data_o[1], 32'h4120_0000);
        check("f7 cnt", pending_cnt_o, 1);
        cycle();

        // Reserve f1, f2, f4 then flush with a write to f2 and an ignored reservation
        reserve(5'd1);
        reserve(5'd2);
        reserve(5'd4);
        idle();
        settle();
        check("four pending cnt", pending_cnt_o, 4);
        cycle();
        flush_i = 1'b1;
        we_i = 2'b10;
        wr_addr_i[1] = 5'd2; wr_data_i[1] = 32'hC000_0000;
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd9;
        cycle();
        idle();
        rd_addr_i[0] = 5'd1; rd_addr_i[1] = 5'd2; rd_addr_i[2] = 5'd4;
        rd_addr_i[3] = 5'd7; rd_addr_i[4] = 5'd9; rd_addr_i[5] = 5'd3;
        settle();
        check("flush cnt", pending_cnt_o, 0);
        check("flush valid", rd_valid_o, 6'b111111);
        check("flush f2 data", rd_data_o[1], 32'hC000_0000);
        cycle();

        // Two pending registers retired in one cycle
        reserve(5'd10);
        reserve(5'd11);
        idle();
        we_i = 2'b11;
        wr_addr_i[0] = 5'd10; wr_data_i[0] = 32'h3F00_0000;
        wr_addr_i[1] = 5'd11; wr_data_i[1] = 32'hBF00_0000;
        settle();
        check("dual clear before cnt", pending_cnt_o, 2);
        cycle();
        idle();
        rd_addr_i[0] = 5'd10; rd_addr_i[1] = 5'd11;
        settle();
        check("dual clear cnt", pending_cnt_o, 0);
        check("dual clear f11", rd_data_o[1], 32'hBF00_0000);
        cycle();

        // Clock enable low: edge ignored
        clk_en_i = 1'b0;
        we_i = 2'b11;
        wr_addr_i[0] = 5'd6;  wr_data_i[0] = 32'hDEAD_BEEF;
        wr_addr_i[1] = 5'd10; wr_data_i[1] = 32'h1111_1111;
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd12;
        rd_addr_i[2] = 5'd6; rd_addr_i[3] = 5'd12;
        cycle();
        idle();
        settle();
        check("clk_en f6 data", rd_data_o[2], 32'h0);
        check("clk_en f10 data", rd_data_o[0], 32'h3F00_0000);
        check("clk_en f12 valid", rd_valid_o[3], 1'b1);
        check("clk_en cnt", pending_cnt_o, 0);
        cycle();

        // f5 pending with data, then asynchronous reset between edges
        we_i = 2'b01;
        wr_addr_i[0] = 5'd5; wr_data_i[0] = 32'h1234_5678;
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd5;
        rd_addr_i[4] = 5'd5;
        cycle();
        idle();
        settle();
        check("f5 pending data", rd_data_o[4], 32'h1234_5678);
        check("f5 pending valid", rd_valid_o[4], 1'b0);
        rst_n_i = 1'b0;
        #1;
        check("async rst f5 data", rd_data_o[4], 32'h0);
        check("async rst f5 valid", rd_valid_o[4], 1'b1);
        check("async rst cnt", pending_cnt_o, 0);
        #1;
        rst_n_i = 1'b1;

        // First edge after reset behaves normally
        we_i = 2'b10;
        wr_addr_i[1] = 5'd5; wr_data_i[1] = 32'h4049_0FDB;
        cycle();
        idle();
        reserve(5'd8);
        idle();
        rd_addr_i[5] = 5'd8;
        settle();
        check("post rst f5 data", rd_data_o[4], 32'h4049_0FDB);
        check("post rst f8 valid", rd_valid_o[5], 1'b0);
        check("post rst cnt", pending_cnt_o, 1);
        cycle();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
